// File: rtl/fetch_pkg.sv
// Shared types for the prefetching fetch stage: queue entry layout, NOP constant
// and the redirect source selection used by fetch_prefetch.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    REDIR_NONE   = 2'd0,
    REDIR_BRANCH = 2'd1,
    REDIR_MRET   = 2'd2,
    REDIR_TRAP   = 2'd3
  } redirect_sel_t;

  // Writeback events are older than the memory-stage branch, so they win.
  function automatic redirect_sel_t redirect_select(input logic trap, input logic mret,
                                                    input logic branch);
    redirect_sel_t sel;
    sel = REDIR_NONE;
    if (trap)        sel = REDIR_TRAP;
    else if (mret)   sel = REDIR_MRET;
    else if (branch) sel = REDIR_BRANCH;
    return sel;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of fetch entries with flush; the head entry is read
// straight out of the storage registers so it is stable for the whole cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  // Flush wins over both operations; pushing into a full or popping an empty queue is ignored.
  assign do_push = push && !flush && (count != CW'(DEPTH));
  assign do_pop  = pop && !flush && (count != '0);

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage with a DEPTH-entry prefetch queue between the instruction bus and
// decode, plus an optional empty-queue bypass into the decode register.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int          DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter bit          BYPASS       = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch,
  input  logic [31:0] branch_vector,
  input  logic        trap,
  input  logic        mret,
  input  logic [31:0] trap_vector,
  input  logic [31:0] mret_vector,
  input  logic        stall,
  input  logic        invalidate,
  output logic [31:0] fetch_address,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  input  logic [31:0] fetch_data,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Bus handshake: a request is accepted in any cycle where fetch_valid && fetch_ready;
  // fetch_data belongs to fetch_address of that same cycle. fetch_valid never depends
  // on fetch_ready.

  redirect_sel_t   redirect_sel;
  logic            redirect;
  logic [31:0]     redirect_vector;
  logic [31:0]     req_pc;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    fifo_head;
  logic            queue_full;
  logic            queue_empty;
  logic            accept;
  logic            decode_free;
  logic            bypass_take;
  logic            push;
  logic            pop;

  assign redirect_sel = redirect_select(trap, mret, branch);
  assign redirect     = (redirect_sel != REDIR_NONE);

  always_comb begin
    redirect_vector = branch_vector;
    case (redirect_sel)
      REDIR_TRAP: redirect_vector = trap_vector;
      REDIR_MRET: redirect_vector = mret_vector;
      default:    redirect_vector = branch_vector;
    endcase
  end

  // The full check ignores a same-cycle pop so the request path never depends on decode.
  assign queue_full    = (fifo_count == CW'(DEPTH));
  assign queue_empty   = (fifo_count == '0);
  assign fetch_address = req_pc;
  assign fetch_valid   = reset && !queue_full && !redirect;
  assign accept        = fetch_valid && fetch_ready;

  assign decode_free = !stall && !invalidate;
  assign bypass_take = BYPASS && decode_free && queue_empty && accept;
  assign push        = accept && !bypass_take;
  assign pop         = decode_free && !redirect && !queue_empty;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .push       (push),
    .push_entry ('{pc: req_pc, instruction: fetch_data}),
    .pop        (pop),
    .head       (fifo_head),
    .count      (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      req_pc <= RESET_VECTOR;
    end else if (redirect) begin
      req_pc <= {redirect_vector[31:2], 2'b00};
    end else if (accept) begin
      req_pc <= req_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_out       <= 1'b0;
      pc_out          <= 32'h0;
      next_pc_out     <= 32'h0;
      instruction_out <= NOP_INSTRUCTION;
    end else if (redirect || invalidate) begin
      valid_out <= 1'b0;
    end else if (stall) begin
      valid_out <= valid_out;
    end else if (!queue_empty) begin
      valid_out       <= 1'b1;
      pc_out          <= fifo_head.pc;
      next_pc_out     <= fifo_head.pc + 32'd4;
      instruction_out <= fifo_head.instruction;
    end else if (bypass_take) begin
      valid_out       <= 1'b1;
      pc_out          <= req_pc;
      next_pc_out     <= req_pc + 32'd4;
      instruction_out <= fetch_data;
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: doc/fetch_prefetch.md
Name: fetch_prefetch

Overview:
- Parametrised successor to the single-entry fetch stage. It decouples instruction-bus latency from decode stalls using a DEPTH-entry prefetch queue.
- It sits between busio (instruction port) and decode. It takes branch redirects from memory and trap/mret redirects from writeback, and stall/invalidate from hazard.
- New behaviour: a valid/ready request handshake with the bus, a configurable queue depth, and an optional empty-queue bypass that cuts redirect-to-decode latency by one cycle.

Parameters:
- DEPTH, 4: prefetch queue entries; a power of two, at least 2.
- RESET_VECTOR, 32'h0000_0000: first fetch address after reset.
- BYPASS, 1: 1 routes a bus response straight to the decode register when the queue is empty and decode is not stalled; 0 always queues the response.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (reset==0 resets)
- branch  in  1  taken branch from memory stage
- branch_vector  in  32  branch target
- trap  in  1  trap taken in writeback
- mret  in  1  mret retired in writeback
- trap_vector  in  32  from csr
- mret_vector  in  32  from csr
- stall  in  1  hazard: hold decode-facing outputs
- invalidate  in  1  hazard: kill decode-facing instruction
- fetch_address  out  32  bus request address
- fetch_valid  out  1  bus request valid
- fetch_ready  in  1  bus accepts request; fetch_data is valid in the same cycle
- fetch_data  in  32  instruction word
- pc_out  out  32  to decode
- next_pc_out  out  32  to decode, equal to pc_out+4
- instruction_out  out  32  to decode
- valid_out  out  1  to decode

Behaviour:
- Reset (reset==0 at edge):
  - req_pc=RESET_VECTOR, queue count=0.
  - valid_out=0, pc_out=0, next_pc_out=0, instruction_out=32'h0000_0013 (NOP).
  - fetch_valid is forced 0 while reset==0.
  - Reset mid-operation discards queue contents and the in-flight response.
- Request side:
  - fetch_address=req_pc (registered).
  - fetch_valid=(count<DEPTH) && no redirect this cycle.
  - Accept = fetch_valid && fetch_ready. On accept, req_pc+=4 with 32-bit wrap (32'hFFFF_FFFC -> 0).
  - A pop in the same cycle does not free space for a request that cycle; the full check is conservative.
- Queue:
  - Each entry holds {pc, instruction}; next_pc is recomputed as pc+4 on pop.
  - Push on accept, except when bypass applies.
  - Pop when !stall && !invalidate && count>0.
  - Simultaneous push and pop leaves count unchanged.
  - Full (count==DEPTH): no requests are issued.
  - Empty with no bypass: valid_out<=0 when not stalled.
- Decode register, evaluated in priority order at each edge:
  1. Redirect: valid_out<=0.
  2. invalidate: valid_out<=0, no pop, queue entry preserved; overrides stall.
  3. stall: hold all outputs.
  4. count>0: load the head entry, valid_out<=1.
  5. BYPASS && count==0 && accept: load req_pc and fetch_data directly, valid_out<=1.
  6. Otherwise: valid_out<=0.
- Redirect:
  - Priority trap > mret > branch. The selected vector with bits [1:0] forced to 0 is loaded into req_pc.
  - Queue flushed (count<=0). Any response accepted in the same cycle is discarded.
- Latency from redirect asserted in cycle N with ready held high:
  - fetch_address=vector in N+1.
  - BYPASS=1: valid_out=1 with pc_out=vector in N+2.
  - BYPASS=0: valid_out=1 with pc_out=vector in N+3.
- Steady state with ready=1 and no stalls: one instruction per cycle.

Decomposition:
- Shared package fetch_pkg:
  - NOP_INSTRUCTION constant (32'h0000_0013).
  - fetch_entry_t struct {pc[31:0], instruction[31:0]}.
  - Redirect-select encoding.
- One natural sub-module: fetch_fifo, a synchronous FIFO of fetch_entry_t, DEPTH-parameterised, with push/pop/flush, count, and a registered head.
- fetch_prefetch holds req_pc, the redirect mux, the bypass path and the decode register.

Test Plan:
1. Reset release, DEPTH=4, BYPASS=1, ready=1, stall=0 -> fetch_address 0,4,8,… on consecutive cycles; valid_out first high one cycle after the first accept with pc_out=0; one instruction per cycle thereafter.
2. stall=1 for 6 cycles, ready=1 -> exactly 4 accepts, then fetch_valid=0 with count=4; outputs held. On stall release, pc_out steps 0,4,8,12,16 with no gap.
3. branch=1 with branch_vector=32'h100 while the queue holds 3 entries -> next cycle fetch_address=32'h100, count=0, valid_out=0. Old entries are never presented; pc_out=32'h100 two cycles after the redirect (BYPASS=1).
4. trap, mret and branch asserted together, with trap_vector=32'h200, mret_vector=32'h300, branch_vector=32'h400 -> req_pc=32'h200. A trap_vector of 32'h203 is fetched as 32'h200.
5. invalidate=1 for one cycle with the queue non-empty -> valid_out=0 next cycle, no entry lost. invalidate and stall together -> valid_out=0.
6. BYPASS=0 with redirect to 32'h40 -> pc_out=32'h40 valid in N+3. A fetch_ready toggling 1,0,1 pattern produces no duplicated or skipped pc. Reset asserted mid-stream -> all outputs at reset values next cycle.
